// File: rtl/robo_limpa_tubos.sv
//==============================================================================
// robo_limpa_tubos: left-hand wall-following FSM for the pipe-cleaning robot.
// Optional debris removal under macro ROBO_REMOVE_EN.  Rev 1.0
//==============================================================================
`default_nettype none

module robo_limpa_tubos #(
   parameter int REMOVE_CYCLES = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic head,
   input  logic left,
   input  logic under,
   input  logic barrier,
   output logic front,
   output logic turn,
   output logic remove
);

   typedef enum logic [2:0] {
      S_SEARCH    = 3'd0,
      S_FOLLOW    = 3'd1,
      S_POST_TURN = 3'd2,
      S_TURN_R    = 3'd3,
      S_DONE      = 3'd5
`ifdef ROBO_REMOVE_EN
      , S_REMOVE  = 3'd4
`endif
   } state_t;

   state_t     r_state;
   state_t     w_nxt_state;
   state_t     w_base;
   logic       w_eval;
   logic [1:0] r_tcnt;
   logic [1:0] w_nxt_tcnt;
   logic       r_front;
   logic       r_turn;
   logic       w_nxt_front;
   logic       w_nxt_turn;

`ifdef ROBO_REMOVE_EN
   localparam logic [3:0] c_rm_cycles = 4'(REMOVE_CYCLES);
   state_t     r_ret;
   state_t     w_nxt_ret;
   logic [3:0] r_rcnt;
   logic [3:0] w_nxt_rcnt;
   logic       r_remove;
   logic       w_nxt_remove;
`else
   logic       w_unused_barrier;
   assign w_unused_barrier = barrier;
`endif

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_front  = 1'b0;
      w_nxt_turn   = 1'b0;
      w_nxt_tcnt   = 2'd0;
      w_eval       = 1'b0;
      w_base       = r_state;
`ifdef ROBO_REMOVE_EN
      w_nxt_remove = 1'b0;
      w_nxt_rcnt   = 4'd0;
      w_nxt_ret    = r_ret;
`endif

      // Timed states run out their count; the edge that ends them is
      // evaluated immediately as the state they hand back to.
      case (r_state)
         S_SEARCH, S_FOLLOW, S_POST_TURN: begin
            w_eval = 1'b1;
            w_base = r_state;
         end
         S_TURN_R: begin
            if (r_tcnt < 2'd3) begin
               w_nxt_turn = 1'b1;
               w_nxt_tcnt = r_tcnt + 2'd1;
            end else begin
               w_eval = 1'b1;
               w_base = S_FOLLOW;
            end
         end
`ifdef ROBO_REMOVE_EN
         S_REMOVE: begin
            if (r_rcnt < c_rm_cycles) begin
               w_nxt_remove = 1'b1;
               w_nxt_rcnt   = r_rcnt + 4'd1;
            end else begin
               w_eval = 1'b1;
               w_base = r_ret;
            end
         end
`endif
         S_DONE: begin
            w_nxt_state = S_DONE;
         end
         default: begin
            w_nxt_state = S_SEARCH;
         end
      endcase

      if (w_eval) begin
         if (under) begin
            w_nxt_state = S_DONE;
         end
`ifdef ROBO_REMOVE_EN
         else if (barrier) begin
            w_nxt_state  = S_REMOVE;
            w_nxt_remove = 1'b1;
            w_nxt_rcnt   = 4'd1;
            w_nxt_ret    = w_base;
         end
`endif
         else if (w_base == S_FOLLOW && !left) begin
            w_nxt_state = S_POST_TURN;
            w_nxt_turn  = 1'b1;
         end else if (head) begin
            w_nxt_state = S_TURN_R;
            w_nxt_turn  = 1'b1;
            w_nxt_tcnt  = 2'd1;
         end else begin
            // SEARCH keeps searching until it feels a wall on the left.
            w_nxt_front = 1'b1;
            w_nxt_state = (w_base == S_SEARCH && !left) ? S_SEARCH : S_FOLLOW;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= S_SEARCH;
         r_tcnt   <= 2'd0;
         r_front  <= 1'b0;
         r_turn   <= 1'b0;
`ifdef ROBO_REMOVE_EN
         r_rcnt   <= 4'd0;
         r_ret    <= S_SEARCH;
         r_remove <= 1'b0;
`endif
      end else begin
         r_state  <= w_nxt_state;
         r_tcnt   <= w_nxt_tcnt;
         r_front  <= w_nxt_front;
         r_turn   <= w_nxt_turn;
`ifdef ROBO_REMOVE_EN
         r_rcnt   <= w_nxt_rcnt;
         r_ret    <= w_nxt_ret;
         r_remove <= w_nxt_remove;
`endif
      end
   end

   assign front  = r_front;
   assign turn   = r_turn;
`ifdef ROBO_REMOVE_EN
   assign remove = r_remove;
`else
   assign remove = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_robo_limpa_tubos.sv
//==============================================================================
// tb_robo_limpa_tubos: directed test of the wall-following FSM.
// Outputs are checked as the vector {front, turn, remove}.  Rev 1.0
//==============================================================================
`default_nettype none

module tb_robo_limpa_tubos;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic head = 1'b0;
   logic left = 1'b0;
   logic under = 1'b0;
   logic barrier = 1'b0;
   logic front;
   logic turn;
   logic remove;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [2:0] FWD  = 3'b100;
   localparam logic [2:0] TRN  = 3'b010;
   localparam logic [2:0] RMV  = 3'b001;
   localparam logic [2:0] IDLE = 3'b000;

   always #5 clock = ~clock;

   robo_limpa_tubos #(.REMOVE_CYCLES(2)) u_dut (
      .clock   (clock),
      .reset   (reset),
      .head    (head),
      .left    (left),
      .under   (under),
      .barrier (barrier),
      .front   (front),
      .turn    (turn),
      .remove  (remove)
   );

   task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: {front,turn,remove} got %b expected %b at %0t", tag, got, exp, $time);
   endtask

   // Apply sensors, take one rising edge, then check the registered outputs.
   task automatic step(input string tag, input logic h, input logic l,
                       input logic u, input logic b, input logic [2:0] exp);
      head = h; left = l; under = u; barrier = b;
      @(posedge clock);
      #1;
      chk(tag, {front, turn, remove}, exp);
   endtask

   initial begin
      // Reset held: outputs stay 0 whatever the sensors do.
      for (int i = 0; i < 3; i++) begin
         head = i[0]; left = i[1]; barrier = ~i[0];
         @(posedge clock);
         #1;
         chk("reset_hold", {front, turn, remove}, IDLE);
      end
      head = 1'b0; left = 1'b0; barrier = 1'b0; under = 1'b0;
      #2 reset = 1'b1;
      step("search_front", 0, 0, 0, 0, FWD);

      // SEARCH finds a left wall, then follows it.
      step("follow_0", 0, 1, 0, 0, FWD);
      for (int i = 0; i < 3; i++) step("follow_run", 0, 1, 0, 0, FWD);
      step("lose_wall_turn", 0, 0, 0, 0, TRN);
      step("post_turn_front", 0, 0, 0, 0, FWD);

      // Corner: exactly three turn cycles; front-worthy sensors ignored meanwhile.
      step("corner_t1", 1, 1, 0, 0, TRN);
      step("corner_t2", 0, 1, 0, 0, TRN);
      step("corner_t3", 0, 1, 0, 0, TRN);
      step("corner_exit", 0, 1, 0, 0, FWD);

`ifdef ROBO_REMOVE_EN
      step("debris_r1", 1, 1, 0, 1, RMV);
      step("debris_r2", 0, 1, 0, 0, RMV);
      step("debris_exit", 0, 1, 0, 0, FWD);
      // Barrier persisting past the removal window triggers another removal.
      step("debris2_r1", 1, 1, 0, 1, RMV);
      step("debris2_r2", 1, 1, 0, 1, RMV);
      step("debris2_again", 1, 1, 0, 1, RMV);
      step("debris2_r4", 1, 1, 0, 1, RMV);
      step("debris2_exit", 0, 1, 0, 0, FWD);
      // Barrier with a clear head is still debris.
      step("debris_nohead", 0, 1, 0, 1, RMV);
      step("debris_nohead2", 0, 1, 0, 0, RMV);
      step("debris_nohead_x", 0, 1, 0, 0, FWD);
`else
      // Without removal, debris is just a wall ahead.
      step("debris_wall_t1", 1, 1, 0, 1, TRN);
      step("debris_wall_t2", 0, 1, 0, 1, TRN);
      step("debris_wall_t3", 0, 1, 0, 1, TRN);
      step("debris_wall_x", 0, 1, 0, 0, FWD);
      step("barrier_ignored", 0, 1, 0, 1, FWD);
`endif

      // End marker beats barrier; DONE ignores everything.
      step("done_enter", 1, 1, 1, 1, IDLE);
      for (int i = 0; i < 10; i++) begin
         step("done_hold", i[0], i[1], i[2], ~i[0], IDLE);
      end

      // Reset leaves DONE and restarts in SEARCH.
      #2 reset = 1'b0;
      #10 reset = 1'b1;
      step("after_done_search", 0, 0, 0, 0, FWD);

      // Async reset during the second TURN_R cycle.
      step("search_turn_t1", 1, 0, 0, 0, TRN);
      step("search_turn_t2", 0, 0, 0, 0, TRN);
      #2 reset = 1'b0;
      #1 chk("async_reset_now", {front, turn, remove}, IDLE);
      @(posedge clock);
      #1 chk("async_reset_held", {front, turn, remove}, IDLE);
      #2 reset = 1'b1;
      step("post_reset_search", 0, 0, 0, 0, FWD);
      step("post_reset_stay", 0, 0, 0, 0, FWD);
      step("post_reset_turn", 1, 0, 0, 0, TRN);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
